// File: rtl/numarator_invers_mmss.sv
// numarator_invers_mmss: mm:ss countdown timer with four BCD digit outputs.
// Loads a clamped preset, decrements once per 1 Hz tick enable and raises an
// alarm at 00:00.
// Optional build macro NUMARATOR_AUTO_RELOAD_EN: on reaching 00:00 the count
// reloads from the preset and keeps running (done still pulses, no alarm).
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | preset loaded or acknowledged; count frozen, waiting for start
// S_RUN     | counting down one step per tick
// S_PAUSED  | started but frozen while pauza is high
// S_EXPIRED | reached 00:00; alarm held until start or load

module numarator_invers_mmss #(
  parameter int MAX_MIN = 59
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [6:0] min_set,
  input  logic [5:0] sec_set,
  input  logic       start,
  input  logic       pauza,
  output logic [3:0] BCD0,
  output logic [3:0] BCD1,
  output logic [3:0] BCD2,
  output logic [3:0] BCD3,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  localparam logic [6:0] MAX_MIN_C = 7'(MAX_MIN);
  localparam logic [5:0] MAX_SEC_C = 6'd59;

  state_t     state_q;
  logic [6:0] min_q;
  logic [5:0] sec_q;
  logic [6:0] rl_min_q;
  logic [5:0] rl_sec_q;
  logic       running_q;
  logic       done_q;
  logic       alarm_q;

  logic [6:0] min_clamp_d;
  logic [5:0] sec_clamp_d;
  logic       count_zero;
  logic       last_step;

  assign min_clamp_d = (min_set > MAX_MIN_C) ? MAX_MIN_C : min_set;
  assign sec_clamp_d = (sec_set > MAX_SEC_C) ? MAX_SEC_C : sec_set;
  assign count_zero  = (min_q == 7'd0) && (sec_q == 6'd0);
  // 00:01 is the only value whose next decrement lands on 00:00
  assign last_step   = (min_q == 7'd0) && (sec_q == 6'd1);

  function automatic logic [3:0] bcd_tens(input logic [6:0] v);
    logic [6:0] t;
    t = v / 7'd10;
    return t[3:0];
  endfunction

  function automatic logic [3:0] bcd_units(input logic [6:0] v);
    logic [6:0] t;
    logic [6:0] u;
    t = v / 7'd10;
    u = v - (t * 7'd10);
    return u[3:0];
  endfunction

  // Timer FSM: load beats start beats tick; count, reload and flags all registered
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      min_q     <= 7'd0;
      sec_q     <= 6'd0;
      rl_min_q  <= 7'd0;
      rl_sec_q  <= 6'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        min_q     <= min_clamp_d;
        sec_q     <= sec_clamp_d;
        rl_min_q  <= min_clamp_d;
        rl_sec_q  <= sec_clamp_d;
        state_q   <= S_IDLE;
        running_q <= 1'b0;
        alarm_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            // starting from 00:00 would expire with no time elapsed, so it is refused
            if (start && !count_zero) begin
              state_q   <= pauza ? S_PAUSED : S_RUN;
              running_q <= 1'b1;
            end
          end
          S_RUN: begin
            if (pauza) begin
              state_q <= S_PAUSED;
            end else if (tick && !count_zero) begin
              if (last_step) begin
`ifdef NUMARATOR_AUTO_RELOAD_EN
                min_q  <= rl_min_q;
                sec_q  <= rl_sec_q;
                done_q <= 1'b1;
`else
                min_q     <= 7'd0;
                sec_q     <= 6'd0;
                state_q   <= S_EXPIRED;
                running_q <= 1'b0;
                done_q    <= 1'b1;
                alarm_q   <= 1'b1;
`endif
              end else if (sec_q != 6'd0) begin
                sec_q <= sec_q - 6'd1;
              end else begin
                min_q <= min_q - 7'd1;
                sec_q <= MAX_SEC_C;
              end
            end
          end
          S_PAUSED: begin
            if (!pauza) begin
              state_q <= S_RUN;
            end
          end
          S_EXPIRED: begin
            if (start) begin
              state_q <= S_IDLE;
              alarm_q <= 1'b0;
            end
          end
          default: begin
            state_q   <= S_IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Display digits follow the registered count with no extra latency
  always_comb begin
    BCD0 = bcd_units({1'b0, sec_q});
    BCD1 = bcd_tens({1'b0, sec_q});
    BCD2 = bcd_units(min_q);
    BCD3 = bcd_tens(min_q);
  end

  assign running = running_q;
  assign done    = done_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_numarator_invers_mmss.sv
module tb_numarator_invers_mmss;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       tick;
  logic       load;
  logic [6:0] min_set;
  logic [5:0] sec_set;
  logic       start;
  logic       pauza;
  logic [3:0] BCD0, BCD1, BCD2, BCD3;
  logic       running, done, alarm;

  int checks = 0;
  int failures = 0;

  numarator_invers_mmss #(.MAX_MIN(59)) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .tick    (tick),
    .load    (load),
    .min_set (min_set),
    .sec_set (sec_set),
    .start   (start),
    .pauza   (pauza),
    .BCD0    (BCD0),
    .BCD1    (BCD1),
    .BCD2    (BCD2),
    .BCD3    (BCD3),
    .running (running),
    .done    (done),
    .alarm   (alarm)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [15:0] disp();
    return {BCD3, BCD2, BCD1, BCD0};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock edge, then settle 1 time unit past it
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_load(input logic [6:0] m, input logic [5:0] s);
    min_set = m; sec_set = s; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; load = 1'b0; start = 1'b0; pauza = 1'b0;
    min_set = 7'd0; sec_set = 6'd0;
    #3;
    chk("rst_bcd", disp(), 16'h0000);
    chk("rst_running", {15'd0, running}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_alarm", {15'd0, alarm}, 16'd0);
    repeat (2) @(posedge clk_in);
    #1 reset = 1'b1;
    step();

    // load / decrement / borrow
    do_load(7'd1, 6'd5);
    chk("t1_load_bcd", disp(), 16'h0105);
    chk("t1_load_running", {15'd0, running}, 16'd0);
    do_start();
    chk("t1_start_running", {15'd0, running}, 16'd1);
    chk("t1_start_bcd", disp(), 16'h0105);
    do_tick();
    chk("t1_tick1_bcd", disp(), 16'h0104);
    repeat (4) do_tick();
    chk("t1_tick5_bcd", disp(), 16'h0100);
    do_tick();
    chk("t1_borrow_bcd", disp(), 16'h0059);
    chk("t1_borrow_running", {15'd0, running}, 16'd1);
    chk("t1_borrow_done", {15'd0, done}, 16'd0);

`ifdef NUMARATOR_AUTO_RELOAD_EN
    // auto reload
    do_load(7'd0, 6'd3);
    do_start();
    repeat (2) do_tick();
    chk("ar_pre_done", {15'd0, done}, 16'd0);
    do_tick();
    chk("ar_done1", {15'd0, done}, 16'd1);
    chk("ar_bcd", disp(), 16'h0003);
    chk("ar_running", {15'd0, running}, 16'd1);
    chk("ar_alarm", {15'd0, alarm}, 16'd0);
    step();
    chk("ar_done_clear", {15'd0, done}, 16'd0);
    repeat (2) do_tick();
    chk("ar_bcd_01", disp(), 16'h0001);
    do_tick();
    chk("ar_done2", {15'd0, done}, 16'd1);
    chk("ar_bcd2", disp(), 16'h0003);
`else
    // expiry and acknowledge
    do_load(7'd0, 6'd2);
    do_start();
    do_tick();
    chk("t2_tick1_done", {15'd0, done}, 16'd0);
    chk("t2_tick1_bcd", disp(), 16'h0001);
    do_tick();
    chk("t2_done", {15'd0, done}, 16'd1);
    chk("t2_alarm", {15'd0, alarm}, 16'd1);
    chk("t2_bcd", disp(), 16'h0000);
    chk("t2_running", {15'd0, running}, 16'd0);
    step();
    chk("t2_done_1cyc", {15'd0, done}, 16'd0);
    chk("t2_alarm_held", {15'd0, alarm}, 16'd1);
    repeat (3) do_tick();
    chk("t2_extra_bcd", disp(), 16'h0000);
    chk("t2_extra_alarm", {15'd0, alarm}, 16'd1);
    chk("t2_extra_done", {15'd0, done}, 16'd0);
    do_start();
    chk("t2_ack_alarm", {15'd0, alarm}, 16'd0);
    chk("t2_ack_running", {15'd0, running}, 16'd0);
`endif

    // pause; start and tick together in IDLE -> start wins, no decrement
    do_load(7'd0, 6'd10);
    start = 1'b1; tick = 1'b1;
    step();
    start = 1'b0; tick = 1'b0;
    chk("t3_start_tick_bcd", disp(), 16'h0010);
    pauza = 1'b1;
    step();
    chk("t3_pause_running", {15'd0, running}, 16'd1);
    repeat (3) do_tick();
    chk("t3_paused_bcd", disp(), 16'h0010);
    chk("t3_paused_running", {15'd0, running}, 16'd1);
    pauza = 1'b0;
    step();
    chk("t3_resume_bcd", disp(), 16'h0010);
    do_tick();
    chk("t3_resume_tick_bcd", disp(), 16'h0009);
    chk("t3_resume_running", {15'd0, running}, 16'd1);

    // clamp and priority
    min_set = 7'd75; sec_set = 6'd63;
    load = 1'b1; start = 1'b1; tick = 1'b1;
    step();
    load = 1'b0; start = 1'b0; tick = 1'b0;
    chk("t4_clamp_bcd", disp(), 16'h5959);
    chk("t4_clamp_running", {15'd0, running}, 16'd0);
    do_tick();
    chk("t4_idle_tick_bcd", disp(), 16'h5959);
    do_load(7'd0, 6'd0);
    do_start();
    chk("t4_zero_start_running", {15'd0, running}, 16'd0);
    chk("t4_zero_start_done", {15'd0, done}, 16'd0);
    step();
    chk("t4_zero_start_done2", {15'd0, done}, 16'd0);

    // reset mid-run, asynchronously between edges
    do_load(7'd2, 6'd30);
    do_start();
    repeat (4) do_tick();
    chk("t5_pre_bcd", disp(), 16'h0226);
    chk("t5_pre_running", {15'd0, running}, 16'd1);
    #2 reset = 1'b0;
    #1;
    chk("t5_async_bcd", disp(), 16'h0000);
    chk("t5_async_running", {15'd0, running}, 16'd0);
    step();
    reset = 1'b1;
    repeat (2) do_tick();
    chk("t5_post_tick_bcd", disp(), 16'h0000);
    do_start();
    chk("t5_post_start_running", {15'd0, running}, 16'd0);
    do_load(7'd0, 6'd5);
    do_start();
    do_tick();
    chk("t5_reload_bcd", disp(), 16'h0004);
    chk("t5_reload_running", {15'd0, running}, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
